mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, memory word-address width.
REQ-002 Parameter DATA_W, default 32, data/instruction word width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch request, level, held until if_valid.
- if_addr  in  ADDR_W  fetch word address (driven from the program counter).
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  one-cycle pulse; if_rdata valid.
- ls_req  in  1  load/store request, level, held until ls_valid.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  data word address.
- ls_wdata  in  DATA_W  store data.
- ls_rdata  out  DATA_W  load data.
- ls_valid  out  1  one-cycle pulse; load data valid or store complete.
- mem_sel  out  ADDR_W  address to the single memory port.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, registered in memory (1-cycle latency).

Function
REQ-004 The block SHALL share one single-port memory between fetch (IF) and load/store (LS) requesters.
REQ-005 The FSM SHALL have the states IDLE, GRANT and RESP, plus a registered owner flag (IF/LS).
REQ-006 IDLE: if any request is high, the block SHALL go to GRANT next cycle, latch the owner, and register mem_sel, mem_we/mem_re and mem_wdata from the winner.
REQ-007 Arbitration: a single requester SHALL win; if both request, the side not granted last SHALL win (2-way round-robin). last_grant SHALL update on every grant.
REQ-008 GRANT (one cycle): for a load or fetch, mem_re=1 and mem_we=0; for a store, mem_we=1, mem_re=0 and mem_wdata=ls_wdata. The state SHALL then go to RESP.
REQ-009 RESP (one cycle): mem_re and mem_we SHALL be 0, and the owner's valid SHALL pulse for exactly one cycle.
- Loads and fetches: the owner's rdata SHALL be loaded from mem_rdata in this cycle and SHALL hold until that owner's next RESP.
- After RESP, the state SHALL go to IDLE.
REQ-010 Latency and throughput:
- Request first seen high in IDLE at cycle N leads to GRANT at N+1 and valid at N+2.
- Throughput SHALL be one transaction per 3 cycles.
REQ-011 Request rules:
- Requesters SHALL hold addr, we and wdata stable from req rise until valid.
- Requests SHALL be ignored in GRANT and RESP.
- A req still high in the cycle after valid SHALL be treated as a new request.
REQ-012 The non-owner's valid SHALL stay 0, and its rdata SHALL be unchanged, throughout a transaction.
REQ-013 With both requesters held high continuously, grants SHALL strictly alternate IF, LS, IF, LS.
REQ-014 ls_we SHALL only be examined at grant; it SHALL be ignored when IF wins.
REQ-015 Address arithmetic: none; addresses SHALL pass through unmodified and truncated to ADDR_W.

Reset
REQ-016 While reset is high at a clock edge, the next state SHALL be:
- state=IDLE, mem_re=0, mem_we=0, if_valid=0, ls_valid=0
- mem_sel=0, mem_wdata=0, if_rdata=0, ls_rdata=0
- last_grant=LS (IF wins the first conflict).
REQ-017 Reset mid-operation SHALL abandon the transaction with no valid pulse. A store whose GRANT cycle coincides with reset MAY complete in memory. The requester SHALL re-issue after reset.
REQ-018 Reset SHALL have priority over all requests.

Structure
REQ-019 The state enum (IDLE/GRANT/RESP), owner encoding (OWN_IF/OWN_LS), ADDR_W and DATA_W defaults SHALL live in the shared cpu package.
REQ-020 The 2-way round-robin choice SHALL be one sub-module, rr_pick2: inputs req_a, req_b, last; outputs gnt_a, gnt_b; combinational, no state.

Verification
REQ-021 Reset, then if_req=1, if_addr=3, memory[3]=0x00100093 -> GRANT at N+1 with mem_sel=3 and mem_re=1; if_valid at N+2 with if_rdata=0x00100093.
REQ-022 ls_req=1, ls_we=1, ls_addr=512, ls_wdata=0x1 -> mem_we=1 and mem_sel=512 for exactly one cycle, then ls_valid at N+2. A subsequent load of 512 -> ls_rdata=0x1.
REQ-023 Simultaneous first requests from both sides after reset -> IF granted first, LS next. Held high for 8 transactions -> alternating IF/LS, 3 cycles each, no missed pulse.
REQ-024 Reset asserted in the GRANT cycle of a load -> no ls_valid, outputs at reset values next cycle. Held ls_req after reset -> load completes normally.
REQ-025 if_req held high for 3 transactions with ls idle -> if_valid every 3rd cycle; ls_valid stays 0 and ls_rdata stays unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RESP = 2'd2} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-port signals of the arbiter; slave = arbiter side.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_valid;
  logic [ADDR_W-1:0] mem_sel;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_rdata, if_valid, ls_rdata, ls_valid, mem_sel, mem_re, mem_we, mem_wdata
  );
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_rdata, if_valid, ls_rdata, ls_valid, mem_sel, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick; last=1 means side b won the previous grant.
module rr_pick2 (
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic gnt_a,
  output logic gnt_b
);
  assign gnt_a = req_a & (~req_b | last);
  assign gnt_b = req_b & (~req_a | ~last);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, 1-cycle-latency memory between fetch and load/store.
// Each transaction is IDLE -> GRANT -> RESP, one cycle each.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic              clock,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);
  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [ADDR_W-1:0] mem_sel_q, mem_sel_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              st_q, st_d;
  logic              if_valid_q, if_valid_d;
  logic              ls_valid_q, ls_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              gnt_if, gnt_ls;
  logic              if_load, ls_load;

  rr_pick2 u_rr (
    .req_a (bus.if_req),
    .req_b (bus.ls_req),
    .last  (last_q == OWN_LS),
    .gnt_a (gnt_if),
    .gnt_b (gnt_ls)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_if || gnt_ls) state_d = GRANT;
      GRANT:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory read data lands in RESP; it is forwarded straight to the owner and
  // captured so the owner's rdata holds until its next response.
  assign if_load = if_valid_q;
  assign ls_load = ls_valid_q & ~st_q;

  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    mem_sel_d   = mem_sel_q;
    mem_wdata_d = mem_wdata_q;
    st_d        = st_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    if_valid_d  = 1'b0;
    ls_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_ls) begin
          owner_d     = OWN_LS;
          last_d      = OWN_LS;
          mem_sel_d   = bus.ls_addr;
          mem_wdata_d = bus.ls_wdata;
          mem_we_d    = bus.ls_we;
          mem_re_d    = ~bus.ls_we;
          st_d        = bus.ls_we;
        end else if (gnt_if) begin
          owner_d   = OWN_IF;
          last_d    = OWN_IF;
          mem_sel_d = bus.if_addr;
          mem_re_d  = 1'b1;
          st_d      = 1'b0;
        end
      end
      GRANT: begin
        if_valid_d = (owner_q == OWN_IF);
        ls_valid_d = (owner_q == OWN_LS);
      end
      RESP: begin
        if (if_load) if_rdata_d = bus.mem_rdata;
        if (ls_load) ls_rdata_d = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q     <= OWN_IF;
      last_q      <= OWN_LS;
      mem_sel_q   <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      st_q        <= 1'b0;
      if_valid_q  <= 1'b0;
      ls_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      mem_sel_q   <= mem_sel_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      st_q        <= st_d;
      if_valid_q  <= if_valid_d;
      ls_valid_q  <= ls_valid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign bus.mem_sel   = mem_sel_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.ls_valid  = ls_valid_q;
  assign bus.if_rdata  = if_load ? bus.mem_rdata : if_rdata_q;
  assign bus.ls_rdata  = ls_load ? bus.mem_rdata : ls_rdata_q;
endmodule
